// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-system types: word type, RAM handshake state and the
// cache/RAM arbiter grant state.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between icache fills and dcache fills/writebacks.
// Dcache has priority unless the icache has waited STARVE_MAX cycles.
//
// state  | meaning
// IDLE   | no grant; decide next owner from current requests and starvation count
// DGRANT | dcache owns the RAM port until ACCESS or it drops its request
// IGRANT | icache owns the RAM port until ACCESS or it drops its request
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 4   // 2**CNT_W must exceed STARVE_MAX
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             d_req, i_starved, i_done;

  always_comb begin
    state_nxt = state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    i_done    = 1'b0;
    d_req     = dREN | dWEN;
    i_starved = iREN && (starve_cnt >= STARVE_LIM);

    case (state)
      IDLE: begin
        if (d_req && !i_starved) state_nxt = DGRANT;
        else if (iREN)           state_nxt = IGRANT;
      end
      DGRANT: begin
        if (!d_req) begin
          state_nxt = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ramstate == ACCESS) begin
            dwait     = 1'b0;
            dload     = ramload;
            state_nxt = IDLE;
          end
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_nxt = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == ACCESS) begin
            iwait     = 1'b0;
            iload     = ramload;
            i_done    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // An access overlapping reset is abandoned: never let a wait drop or an enable reach RAM.
    if (!nRST) begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
    end

    if (!iREN || i_done)
      starve_nxt = '0;
    else if (state != IGRANT && starve_cnt != CNT_SAT)
      starve_nxt = starve_cnt + 1'b1;
    else
      starve_nxt = starve_cnt;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios followed by randomized traffic,
// all outputs compared each cycle against a transaction-level owner/counter model.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int STARVE_MAX = 8;
  localparam int CNT_MAX    = 15;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  ramstate_t   ramstate;

  int tests = 0;
  int fails = 0;

  // model: who holds the RAM port (0 none, 1 dcache, 2 icache) and how long icache has waited
  int m_owner = 0;
  int m_cnt   = 0;

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic        e_rren, e_rwen, e_iwait, e_dwait;
    logic [31:0] e_raddr, e_rstore, e_iload, e_dload;
    e_rren = 1'b0; e_rwen = 1'b0; e_iwait = 1'b1; e_dwait = 1'b1;
    e_raddr = '0; e_rstore = '0; e_iload = '0; e_dload = '0;
    if (nRST === 1'b1) begin
      if (m_owner == 1 && (dREN || dWEN)) begin
        e_raddr  = daddr;
        e_rstore = dstore;
        e_rwen   = dWEN;
        e_rren   = dREN && !dWEN;
        if (ramstate == ACCESS) begin
          e_dwait = 1'b0;
          e_dload = ramload;
        end
      end
      if (m_owner == 2 && iREN) begin
        e_raddr = iaddr;
        e_rren  = 1'b1;
        if (ramstate == ACCESS) begin
          e_iwait = 1'b0;
          e_iload = ramload;
        end
      end
    end
    chk1("ramREN", ramREN, e_rren);
    chk1("ramWEN", ramWEN, e_rwen);
    chk32("ramaddr", ramaddr, e_raddr);
    chk32("ramstore", ramstore, e_rstore);
    chk1("iwait", iwait, e_iwait);
    chk1("dwait", dwait, e_dwait);
    chk32("iload", iload, e_iload);
    chk32("dload", dload, e_dload);
  endtask

  task automatic model_step();
    bit i_fin;
    if (nRST !== 1'b1) begin
      m_owner = 0;
      m_cnt   = 0;
    end else begin
      i_fin = (m_owner == 2) && iREN && (ramstate == ACCESS);
      if (!iREN || i_fin)  m_cnt = 0;
      else if (m_owner != 2) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      case (m_owner)
        0: begin
          if ((dREN || dWEN) && !(iREN && m_cnt_before_ge())) m_owner = 1;
          else if (iREN) m_owner = 2;
        end
        1: if (!(dREN || dWEN) || ramstate == ACCESS) m_owner = 0;
        default: if (!iREN || ramstate == ACCESS) m_owner = 0;
      endcase
    end
  endtask

  // the arbitration decision uses the count held before this edge's update
  int m_cnt_prev = 0;
  function automatic bit m_cnt_before_ge();
    return m_cnt_prev >= STARVE_MAX;
  endfunction

  task automatic cycle();
    #1;
    check_all();
    @(posedge CLK);
    m_cnt_prev = m_cnt;
    model_step();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    ramstate = FREE;
  endtask

  int d_before_i, d_after_i, i_idx;

  initial begin
    nRST = 1'b0;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0;
    ramstate = FREE;
    @(negedge CLK);

    // reset held with both requests asserted
    repeat (3) begin
      #1;
      chk1("rst_ramREN", ramREN, 1'b0);
      chk1("rst_iwait", iwait, 1'b1);
      chk1("rst_dwait", dwait, 1'b1);
      cycle();
    end
    nRST = 1'b1;
    #1; chk1("post_rst_idle_ramREN", ramREN, 1'b0);
    cycle();
    #1; chk1("post_rst_grant_ramREN", ramREN, 1'b1);
    chk1("post_rst_grant_iwait", iwait, 1'b1);
    ramstate = ACCESS;
    cycle();
    idle_inputs();
    cycle(); cycle();

    // dcache read, ACCESS on third granted cycle
    dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
    cycle();
    #1; chk1("dread_g1_ramREN", ramREN, 1'b1);
    chk32("dread_g1_addr", ramaddr, 32'h100);
    chk1("dread_g1_dwait", dwait, 1'b1);
    cycle(); cycle();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1; chk1("dread_done_dwait", dwait, 1'b0);
    chk32("dread_done_dload", dload, 32'hDEADBEEF);
    cycle();
    #1; chk1("dread_after_dwait", dwait, 1'b1);
    chk1("dread_after_ramREN", ramREN, 1'b0);
    cycle();
    idle_inputs();
    cycle(); cycle();

    // simultaneous icache read and dcache write
    iREN = 1'b1; iaddr = 32'h200; dWEN = 1'b1; daddr = 32'h40; dstore = 32'h12345678;
    ramstate = ACCESS; ramload = 32'hCAFE0001;
    cycle();
    #1; chk1("wr_ramWEN", ramWEN, 1'b1);
    chk1("wr_ramREN", ramREN, 1'b0);
    chk32("wr_ramstore", ramstore, 32'h12345678);
    chk32("wr_ramaddr", ramaddr, 32'h40);
    chk1("wr_iwait", iwait, 1'b1);
    cycle();
    dWEN = 1'b0;
    #1; chk1("wr_gap_ramREN", ramREN, 1'b0);
    cycle();
    #1; chk1("ifill_ramREN", ramREN, 1'b1);
    chk32("ifill_addr", ramaddr, 32'h200);
    chk1("ifill_iwait", iwait, 1'b0);
    chk32("ifill_iload", iload, 32'hCAFE0001);
    cycle();
    idle_inputs();
    cycle(); cycle();

    // starvation guard: dcache re-requests every pass
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h300; daddr = 32'h304;
    ramstate = ACCESS; ramload = 32'h5A5A0000;
    d_before_i = 0; d_after_i = 0; i_idx = -1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (iwait === 1'b0 && i_idx < 0) i_idx = k;
      if (dwait === 1'b0) begin
        if (i_idx < 0) d_before_i++;
        else           d_after_i++;
      end
      cycle();
    end
    chk_int("starve_d_grants_before_i", d_before_i, 4);
    chk_int("starve_i_cycle", i_idx, 9);
    chk_int("starve_d_after_i", d_after_i, 1);
    idle_inputs();
    cycle(); cycle();

    // dcache aborts while RAM is busy
    dREN = 1'b1; daddr = 32'h500; ramstate = BUSY;
    cycle();
    #1; chk1("abort_pre_ramREN", ramREN, 1'b1);
    cycle();
    dREN = 1'b0;
    #1; chk1("abort_ramREN", ramREN, 1'b0);
    chk1("abort_dwait", dwait, 1'b1);
    cycle();
    iREN = 1'b1; iaddr = 32'h504; ramstate = ACCESS; ramload = 32'h77770504;
    #1; chk1("abort_idle_iwait", iwait, 1'b1);
    chk1("abort_idle_ramREN", ramREN, 1'b0);
    cycle();
    #1; chk1("abort_then_i_iwait", iwait, 1'b0);
    cycle();
    idle_inputs();
    cycle(); cycle();

    // RAM ERROR retry on an icache fill
    iREN = 1'b1; iaddr = 32'h8; ramstate = ERROR; ramload = 32'h0BADF00D;
    cycle();
    repeat (4) begin
      #1; chk1("err_ramREN", ramREN, 1'b1);
      chk1("err_iwait", iwait, 1'b1);
      cycle();
    end
    ramstate = ACCESS; ramload = 32'h11110008;
    #1; chk1("err_done_iwait", iwait, 1'b0);
    chk32("err_done_iload", iload, 32'h11110008);
    cycle();
    idle_inputs();
    cycle(); cycle();

    // reset arrives on the cycle the RAM completes
    dREN = 1'b1; daddr = 32'h600; ramstate = BUSY;
    cycle(); cycle();
    nRST = 1'b0; ramstate = ACCESS; ramload = 32'h66666666;
    #1; chk1("midrst_dwait", dwait, 1'b1);
    chk1("midrst_ramREN", ramREN, 1'b0);
    chk32("midrst_dload", dload, 32'h0);
    cycle();
    nRST = 1'b1; dREN = 1'b0; ramstate = FREE;
    #1; chk1("midrst_after_ramREN", ramREN, 1'b0);
    cycle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      nRST     = ($urandom_range(0, 49) != 0);
      iREN     = ($urandom_range(0, 3) != 0);
      dREN     = ($urandom_range(0, 2) == 0);
      dWEN     = ($urandom_range(0, 3) == 0);
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
